regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_reg_n.sv | 27 ++
 rtl/regfile.sv | 62 ++++++
 tb/tb_regfile.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared CPU constants for the register file: data width, register count,
// index width and the hardwired-zero register.
package regfile_pkg;

  localparam int unsigned CPU_DATA_W   = 64;
  localparam int unsigned CPU_NUM_REGS = 32;
  localparam int unsigned REG_IDX_W    = 5;
  localparam int unsigned ZERO_REG     = 31;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_reg_n.sv
// Enable-gated DATA_W-bit register with asynchronous active-high clear.
module reg_n #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en_i) data_d = d_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/regfile.sv
// 31 writable registers plus a constant-zero top register; one decoded write
// port and two combinational read ports built from binary 2:1 mux trees.
module regfile
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = CPU_DATA_W,
  parameter int unsigned NUM_REGS = CPU_NUM_REGS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RegWrite,
  input  logic [REG_IDX_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0]    WriteData,
  input  logic [REG_IDX_W-1:0] ReadRegister1,
  input  logic [REG_IDX_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0]    ReadData1,
  output logic [DATA_W-1:0]    ReadData2
);

  localparam int unsigned ZERO_IDX = NUM_REGS - 1;
  localparam int unsigned LEAVES   = 2 ** REG_IDX_W;

  logic [ZERO_IDX-1:0] wr_en;
  logic [DATA_W-1:0]   reg_q  [ZERO_IDX];
  logic [DATA_W-1:0]   tree1  [1:2*LEAVES-1];
  logic [DATA_W-1:0]   tree2  [1:2*LEAVES-1];

  // One-hot write decode; the zero register has no enable at all.
  for (genvar i = 0; i < ZERO_IDX; i++) begin : g_regs
    assign wr_en[i] = RegWrite & (WriteRegister == REG_IDX_W'(i));

    reg_n #(.W(DATA_W)) u_reg (
      .clk   (clk),
      .reset (reset),
      .en_i  (wr_en[i]),
      .d_i   (WriteData),
      .q_o   (reg_q[i])
    );
  end

  // Heap-ordered leaves: node LEAVES+k is register k; unused/zero slots read 0.
  for (genvar k = 0; k < LEAVES; k++) begin : g_leaf
    if (k < ZERO_IDX) begin : g_live
      assign tree1[LEAVES+k] = reg_q[k];
      assign tree2[LEAVES+k] = reg_q[k];
    end else begin : g_zero
      assign tree1[LEAVES+k] = '0;
      assign tree2[LEAVES+k] = '0;
    end
  end

  // Node n at depth D steers on index bit (MSB - D) between its two children.
  for (genvar n = 1; n < LEAVES; n++) begin : g_mux
    localparam int unsigned D = $clog2(n + 1) - 1;
    assign tree1[n] = ReadRegister1[REG_IDX_W-1-D] ? tree1[2*n+1] : tree1[2*n];
    assign tree2[n] = ReadRegister2[REG_IDX_W-1-D] ? tree2[2*n+1] : tree2[2*n];
  end

  assign ReadData1 = tree1[1];
  assign ReadData2 = tree2[1];

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios followed by random
// traffic compared against an array model of the architectural registers.
module tb_regfile;
  import regfile_pkg::*;

  logic                  clk;
  logic                  reset;
  logic                  RegWrite;
  logic [REG_IDX_W-1:0]  WriteRegister;
  logic [CPU_DATA_W-1:0] WriteData;
  logic [REG_IDX_W-1:0]  ReadRegister1;
  logic [REG_IDX_W-1:0]  ReadRegister2;
  logic [CPU_DATA_W-1:0] ReadData1;
  logic [CPU_DATA_W-1:0] ReadData2;

  logic [CPU_DATA_W-1:0] model [CPU_NUM_REGS];
  int checks = 0;
  int errors = 0;

  regfile dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [CPU_DATA_W-1:0] obs,
                       input logic [CPU_DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and apply the architectural write rule to the model.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < CPU_NUM_REGS; r++) model[r] = '0;
    end else if (RegWrite && int'(WriteRegister) != ZERO_REG) begin
      model[WriteRegister] = WriteData;
    end
    #1;
  endtask

  task automatic write_reg(input int idx, input logic [CPU_DATA_W-1:0] val);
    RegWrite      = 1'b1;
    WriteRegister = REG_IDX_W'(idx);
    WriteData     = val;
    tick();
    RegWrite      = 1'b0;
  endtask

  task automatic read_both(input string tag, input int idx);
    ReadRegister1 = REG_IDX_W'(idx);
    ReadRegister2 = REG_IDX_W'(idx);
    #1;
    check({tag, "_rd1"}, ReadData1, model[idx]);
    check({tag, "_rd2"}, ReadData2, model[idx]);
  endtask

  initial begin
    for (int r = 0; r < CPU_NUM_REGS; r++) model[r] = '0;
    reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd30;
    #1;
    check("reset_rd1", ReadData1, 64'h0);
    check("reset_rd2", ReadData2, 64'h0);
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset asserted mid-cycle clears immediately, without a clock edge.
    write_reg(5, 64'hDEAD_BEEF);
    read_both("x5_written", 5);
    reset = 1'b1;
    #1;
    check("async_reset_x5", ReadData1, 64'h0);
    for (int r = 0; r < CPU_NUM_REGS; r++) model[r] = '0;
    reset = 1'b0;
    #1;

    // Fill every writable register and read each back on both ports.
    for (int i = 0; i < 31; i++) write_reg(i, 64'h1111_0000_0000_0000 + 64'(i));
    for (int i = 0; i < 31; i++) read_both("fill", i);
    check("fill_x30_const", model[30], 64'h1111_0000_0000_001E);

    write_reg(31, 64'hFFFF_FFFF_FFFF_FFFF);
    read_both("zero_reg", 31);
    check("zero_reg_const", ReadData1, 64'h0);

    RegWrite = 1'b0; WriteRegister = 5'd3; WriteData = 64'hABCD;
    tick();
    read_both("wr_disable", 3);
    check("wr_disable_const", ReadData1, 64'h1111_0000_0000_0003);

    // Same-cycle read and write: old value before the edge, new after.
    write_reg(7, 64'h7);
    ReadRegister1 = 5'd7; ReadRegister2 = 5'd7;
    RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 64'h77;
    #1;
    check("rw_before_edge", ReadData1, 64'h7);
    tick();
    RegWrite = 1'b0;
    #1;
    check("rw_after_edge1", ReadData1, 64'h77);
    check("rw_after_edge2", ReadData2, 64'h77);

    // Reset wins over a write on the same edge.
    reset = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd2; WriteData = 64'h22;
    tick();
    RegWrite = 1'b0;
    reset = 1'b0;
    #1;
    read_both("reset_vs_write", 2);
    check("reset_vs_write_const", ReadData2, 64'h0);
    read_both("reset_vs_write_x30", 30);

    // Random traffic: reads checked before each edge against the model.
    for (int c = 0; c < 400; c++) begin
      RegWrite      = 1'($urandom_range(0, 1));
      WriteRegister = REG_IDX_W'($urandom_range(0, 31));
      WriteData     = {$urandom, $urandom};
      ReadRegister1 = REG_IDX_W'($urandom_range(0, 31));
      ReadRegister2 = (c % 5 == 0) ? ReadRegister1 : REG_IDX_W'($urandom_range(0, 31));
      #1;
      check("rand_rd1", ReadData1, model[ReadRegister1]);
      check("rand_rd2", ReadData2, model[ReadRegister2]);
      tick();
    end
    RegWrite = 1'b0;
    for (int i = 0; i < 32; i++) read_both("final_sweep", i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
